alu_reg_ram_seq: RTL and testbench
==================================

ALU_REG_RAM_SEQ -- requirements
Module: alu_reg_ram_seq

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 64, datapath width; REG_COUNT, default 32, register-file depth; RAM_DEPTH, default 128, RAM words. RW = ceil(log2(REG_COUNT)), AW = ceil(log2(RAM_DEPTH)).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports, as name, direction, width, meaning:
- clock in 1: rising-edge clock.
- reset in 1: async active-low reset.
- start in 1: request one operation.
- loadReg in 1: write data into writeReg; honoured only when idle.
- op in 5: ALU operation.
- cin in 1: ALU carry-in.
- muxSel in 1: A operand source; 0 = reg[readA], 1 = data.
- readA in RW: A operand register index.
- readB in RW: B operand register index.
- writeReg in RW: destination register index.
- data in DATA_WIDTH: load value or immediate.
- wbEn in 1: write the result back to writeReg.
- writeRam in 1: store the result at ramAddr.
- ramAddr in AW: RAM address.
- busy out 1: operation in progress.
- done out 1: one-cycle completion pulse.
- aluOut out DATA_WIDTH: latched result.
- status out 4: latched {V,C,N,Z}.
- Cout out 1: equals status[2].
- ramOut out DATA_WIDTH: registered RAM read data.

Function
REQ-004 FSM SHALL have states IDLE, READ, EXEC, WRITE and DONE, one cycle each. In IDLE with start=1 it moves to READ. The sequence READ→EXEC→WRITE→DONE→IDLE is unconditional.
REQ-005 On the edge that accepts start, the block SHALL capture op, cin, muxSel, readA, readB, writeReg, data, wbEn, writeRam and ramAddr into command registers. Input changes while busy SHALL have no effect.
REQ-006 busy SHALL be 1 in READ, EXEC, WRITE and DONE. done SHALL be 1 only in DONE. Latency SHALL be start accepted → done high 4 cycles later.
REQ-007 start SHALL be ignored when not IDLE. A start issued in DONE SHALL NOT be queued.
REQ-008 READ SHALL latch A = muxSel ? data : reg[readA], and B = reg[readB].
REQ-009 EXEC SHALL latch aluOut and status. op encodings:
- 00000: A&B.
- 00001: A|B.
- 00010: A^B.
- 00011: ~A.
- 10000: A+B+cin.
- 10010: A+~B+cin.
- 10100: A>>1, logical.
- 10101: A<<1.
- Any other op: result 0.
REQ-010 Status flags SHALL be: Z = (result==0); N = result MSB; C = carry out of MSB for 10000/10010, else 0; V = signed overflow for 10000/10010, else 0. All arithmetic is modulo 2^DATA_WIDTH.
REQ-011 WRITE SHALL write aluOut to reg[writeReg] if wbEn, and to RAM[ramAddr] if writeRam. Both may occur in the same cycle.
REQ-012 Register REG_COUNT-1 SHALL read as 0 and ignore writes.
REQ-013 In IDLE with loadReg=1 and start=0, data SHALL be written to reg[writeReg] on that edge. loadReg together with start SHALL execute start only. loadReg while busy SHALL be ignored.
REQ-014 ramOut SHALL update every edge with RAM[ramAddr], using the live ramAddr input. A read that collides with a write to the same address SHALL return the old data.
REQ-015 A register written in one cycle SHALL be visible to a READ in a later cycle. No same-cycle bypass is required.

Reset
REQ-016 reset=0 SHALL asynchronously force:
- State to IDLE.
- busy, done, aluOut, status, Cout and ramOut to 0.
- All registers and command registers to 0.
REQ-017 RAM contents SHALL NOT be cleared by reset.
REQ-018 Reset asserted mid-operation SHALL abort the operation. No later register or RAM write from that operation SHALL occur.
REQ-019 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-020 Reset: hold reset=0 with start=1 → busy=0, done=0, aluOut=0, status=0, and all registers read 0.
REQ-021 Add: load r29=14 and r30=14; start with op=10000, cin=0, readA=30, readB=29, wbEn=1, writeReg=1 → done 4 cycles later, aluOut=28, status=4'b0000, r1=28.
REQ-022 Subtract and store: r30=14, r29=14; op=10010, cin=1, writeRam=1, ramAddr=5 → aluOut=0, status=4'b0101. A following read with ramAddr=5 → ramOut=0. Then op=10100 on A=14 → aluOut=7.
REQ-023 Overflow: r2=0x7FFF_FFFF_FFFF_FFFF, r3=1; op=10000, cin=0 → aluOut=0x8000_0000_0000_0000, status=4'b1010.
REQ-024 Hazards:
- start pulsed while busy → no second done.
- readA changed mid-op → result unchanged.
- reset=0 in EXEC → no writeback to writeReg and no RAM write.
- loadReg to r31 → r31 reads 0.

Source files
------------

// File: rtl/alu_reg_ram_seq_if.sv
// Command/result bus of the sequenced ALU + register file + RAM block.
interface alu_reg_ram_seq_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 32,
  parameter int RAM_DEPTH  = 128
);
  localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic                  start;
  logic                  loadReg;
  logic [4:0]            op;
  logic                  cin;
  logic                  muxSel;
  logic [RW-1:0]         readA;
  logic [RW-1:0]         readB;
  logic [RW-1:0]         writeReg;
  logic [DATA_WIDTH-1:0] data;
  logic                  wbEn;
  logic                  writeRam;
  logic [AW-1:0]         ramAddr;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] aluOut;
  logic [3:0]            status;
  logic                  Cout;
  logic [DATA_WIDTH-1:0] ramOut;

  modport master (
    output start, loadReg, op, cin, muxSel, readA, readB, writeReg, data,
           wbEn, writeRam, ramAddr,
    input  busy, done, aluOut, status, Cout, ramOut
  );

  modport slave (
    input  start, loadReg, op, cin, muxSel, readA, readB, writeReg, data,
           wbEn, writeRam, ramAddr,
    output busy, done, aluOut, status, Cout, ramOut
  );
endinterface

// File: rtl/alu_reg_ram_seq.sv
// Multi-cycle ALU sequencer: IDLE -> READ -> EXEC -> WRITE -> DONE.
// Operands come from a register file (top register hardwired to zero) or the
// immediate; results can be written back to the register file and/or a RAM
// whose registered read port follows the live ramAddr input.
module alu_reg_ram_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 32,
  parameter int RAM_DEPTH  = 128
) (
  input logic              clock,
  input logic              reset,
  alu_reg_ram_seq_if.slave bus
);
  localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [RW-1:0] ZREG = RW'(REG_COUNT - 1);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;

  state_t state, state_nxt;
  logic   cap, ld, busy_c, done_c;

  // command registers captured when start is accepted
  logic [4:0]            op_p0;
  logic                  cin_p0, mux_p0, wben_p0, wram_p0;
  logic [RW-1:0]         ra_p0, rb_p0, wr_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [AW-1:0]         addr_p0;
  // operands latched in READ
  logic [DATA_WIDTH-1:0] a_p1, b_p1;
  // result and flags latched in EXEC
  logic [DATA_WIDTH-1:0] res_p2;
  logic [3:0]            flags_p2;

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] ram  [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  // ALU: returns {V, C, N, Z, result}
  function automatic logic [DATA_WIDTH+3:0] alu_eval(
    input logic [4:0]            op,
    input logic                  cin,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0]          sum;
    logic [DATA_WIDTH-1:0]        bop, res;
    logic signed [DATA_WIDTH-1:0] sa, sb, sr;
    logic                         c, v, arith;
    sum   = '0;
    bop   = b;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    arith = 1'b0;
    case (op)
      5'b00000: res = a & b;
      5'b00001: res = a | b;
      5'b00010: res = a ^ b;
      5'b00011: res = ~a;
      5'b10000, 5'b10010: begin
        arith = 1'b1;
        bop   = (op == 5'b10010) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bop} + {{DATA_WIDTH{1'b0}}, cin};
        res   = sum[DATA_WIDTH-1:0];
      end
      5'b10100: res = a >> 1;
      5'b10101: res = a << 1;
      default:  res = '0;
    endcase
    sa = $signed(a);
    sb = $signed(bop);
    sr = $signed(res);
    if (arith) begin
      c = sum[DATA_WIDTH];
      // same-sign operands producing an opposite-sign result
      v = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
    end
    return {v, c, res[DATA_WIDTH-1], (res == '0), res};
  endfunction

  assign rd_a = (ra_p0 == ZREG) ? '0 : regs[ra_p0];
  assign rd_b = (rb_p0 == ZREG) ? '0 : regs[rb_p0];

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state and control decode
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    ld        = 1'b0;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        cap    = bus.start;
        ld     = bus.loadReg && !bus.start;
        if (bus.start) state_nxt = READ;
      end
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy_c    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- stage p0: command capture on the accepting edge ----
  // command registers, frozen for the whole operation
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_p0   <= '0;
      cin_p0  <= 1'b0;
      mux_p0  <= 1'b0;
      ra_p0   <= '0;
      rb_p0   <= '0;
      wr_p0   <= '0;
      data_p0 <= '0;
      wben_p0 <= 1'b0;
      wram_p0 <= 1'b0;
      addr_p0 <= '0;
    end else if (cap) begin
      op_p0   <= bus.op;
      cin_p0  <= bus.cin;
      mux_p0  <= bus.muxSel;
      ra_p0   <= bus.readA;
      rb_p0   <= bus.readB;
      wr_p0   <= bus.writeReg;
      data_p0 <= bus.data;
      wben_p0 <= bus.wbEn;
      wram_p0 <= bus.writeRam;
      addr_p0 <= bus.ramAddr;
    end
  end

  // ---- stage p1: operand fetch (READ) ----
  // operand latches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_p1 <= '0;
      b_p1 <= '0;
    end else if (state == READ) begin
      a_p1 <= mux_p0 ? data_p0 : rd_a;
      b_p1 <= rd_b;
    end
  end

  // ---- stage p2: execute (EXEC) ----
  // result and flag latches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_p2   <= '0;
      flags_p2 <= '0;
    end else if (state == EXEC) begin
      {flags_p2, res_p2} <= alu_eval(op_p0, cin_p0, a_p1, b_p1);
    end
  end

  // ---- writeback (WRITE) ----
  // register file: idle loads and result writeback, top register never written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (ld) begin
      if (bus.writeReg != ZREG) regs[bus.writeReg] <= bus.data;
    end else if (state == WRITE && wben_p0) begin
      if (wr_p0 != ZREG) regs[wr_p0] <= res_p2;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clock) begin
    if (state == WRITE && wram_p0) ram[addr_p0] <= res_p2;
  end

  // registered RAM read on the live address, returns pre-write data on collision
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ram_q <= '0;
    else        ram_q <= ram[bus.ramAddr];
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.aluOut = res_p2;
  assign bus.status = flags_p2;
  assign bus.Cout   = flags_p2[2];
  assign bus.ramOut = ram_q;
endmodule

// File: tb/tb_alu_reg_ram_seq.sv
// Self-checking bench for alu_reg_ram_seq: directed vector table, hand
// sequences for reset/hazard cases, and random operations against a model.
module tb_alu_reg_ram_seq;
  localparam int DW = 64;
  localparam int RC = 32;
  localparam int RD = 128;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alu_reg_ram_seq_if #(.DATA_WIDTH(DW), .REG_COUNT(RC), .RAM_DEPTH(RD)) bus ();

  alu_reg_ram_seq #(.DATA_WIDTH(DW), .REG_COUNT(RC), .RAM_DEPTH(RD)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]    op;
    logic          cin;
    logic          mux;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic [3:0]    st;
  } vec_t;

  vec_t          vecs [16];
  logic [DW-1:0] m_reg [RC];
  logic [DW-1:0] m_ram [RD];
  bit            m_ram_ok [RD];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            ld_extra = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference ALU from the arithmetic definitions: {V, C, N, Z, result}
  function automatic logic [DW+3:0] model_alu(input logic [4:0] op, input logic cin,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0]        r, bb;
    logic [DW+1:0]        u;
    logic signed [DW+1:0] s, rs;
    logic                 c, v;
    r = '0; bb = b; u = '0; s = '0; rs = '0; c = 1'b0; v = 1'b0;
    if (op == 5'b10000 || op == 5'b10010) begin
      if (op == 5'b10010) bb = ~b;
      u  = {2'b00, a} + {2'b00, bb} + {{(DW+1){1'b0}}, cin};
      s  = $signed({{2{a[DW-1]}}, a}) + $signed({{2{bb[DW-1]}}, bb}) + $signed({{(DW+1){1'b0}}, cin});
      r  = u[DW-1:0];
      c  = (u > {2'b00, {DW{1'b1}}});
      rs = $signed({{2{r[DW-1]}}, r});
      v  = (s != rs);
    end else begin
      case (op)
        5'b00000: r = a & b;
        5'b00001: r = a | b;
        5'b00010: r = a ^ b;
        5'b00011: r = ~a;
        5'b10100: r = a >> 1;
        5'b10101: r = a << 1;
        default:  r = '0;
      endcase
    end
    return {v, c, r[DW-1], (r == '0), r};
  endfunction

  task automatic do_op(input logic [4:0] op, input logic cin, input logic mux,
                       input int ra, input int rb, input int wr, input logic [DW-1:0] d,
                       input logic wben, input logic wram, input int addr, input bit quiet,
                       output logic [DW-1:0] res, output logic [3:0] st);
    logic [DW+3:0] e;
    logic [DW-1:0] a, old;
    bit            old_ok;
    int            cyc;
    a      = mux ? d : m_reg[ra];
    e      = model_alu(op, cin, a, m_reg[rb]);
    old    = m_ram[addr];
    old_ok = m_ram_ok[addr];
    @(negedge clock);
    bus.start = 1'b1; bus.loadReg = ld_extra; bus.op = op; bus.cin = cin; bus.muxSel = mux;
    bus.readA = 5'(ra); bus.readB = 5'(rb); bus.writeReg = 5'(wr); bus.data = d;
    bus.wbEn = wben; bus.writeRam = wram; bus.ramAddr = 7'(addr);
    @(posedge clock);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (!bus.done) begin
        bus.start   = quiet ? 1'b1 : 1'($urandom);
        bus.loadReg = quiet ? 1'b0 : 1'($urandom);
        if (!quiet) begin
          bus.op = 5'($urandom); bus.cin = 1'($urandom); bus.muxSel = 1'($urandom);
          bus.readA = 5'($urandom); bus.readB = 5'($urandom); bus.writeReg = 5'($urandom);
          bus.data = {$urandom, $urandom}; bus.wbEn = 1'($urandom);
          bus.writeRam = 1'($urandom); bus.ramAddr = 7'($urandom);
        end
      end
    end while (!bus.done && cyc < 12);
    check("latency", 64'(cyc), 64'd4);
    res = bus.aluOut;
    st  = bus.status;
    check("aluOut", bus.aluOut, e[DW-1:0]);
    check("status", 64'(bus.status), 64'(e[DW+3:DW]));
    check("Cout", 64'(bus.Cout), 64'(e[DW+2]));
    if (quiet && old_ok) check("ram_collision_old", bus.ramOut, old);
    bus.start = 1'b1; bus.loadReg = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    check("no_requeue_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    if (wben && wr != RC - 1) m_reg[wr] = e[DW-1:0];
    if (wram) begin
      m_ram[addr]    = e[DW-1:0];
      m_ram_ok[addr] = 1'b1;
    end
  endtask

  task automatic load_reg(input int r, input logic [DW-1:0] v);
    @(negedge clock);
    bus.loadReg = 1'b1; bus.start = 1'b0; bus.writeReg = 5'(r); bus.data = v;
    @(posedge clock);
    @(negedge clock);
    bus.loadReg = 1'b0;
    if (r != RC - 1) m_reg[r] = v;
  endtask

  task automatic read_reg(input int r, output logic [DW-1:0] v);
    logic [3:0] s;
    do_op(5'b00001, 1'b0, 1'b0, r, r, 0, '0, 1'b0, 1'b0, 0, 1'b1, v, s);
  endtask

  task automatic check_ram(input int addr);
    @(negedge clock);
    bus.ramAddr = 7'(addr);
    @(posedge clock);
    @(negedge clock);
    if (m_ram_ok[addr]) check("ramOut", bus.ramOut, m_ram[addr]);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [3:0]    s;
    logic [4:0]    ops_tab [9];
    int            addr;
    logic [4:0]    op;
    logic          wram;

    ops_tab = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b10000, 5'b10010, 5'b10100, 5'b10101, 5'b11111};
    vecs[0]  = '{5'b10000, 1'b0, 1'b0, 64'd14, 64'd14, 64'd28, 4'b0000};
    vecs[1]  = '{5'b10010, 1'b1, 1'b0, 64'd14, 64'd14, 64'd0, 4'b0101};
    vecs[2]  = '{5'b10000, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010};
    vecs[3]  = '{5'b00000, 1'b0, 1'b0, 64'hFF00, 64'h0FF0, 64'h0F00, 4'b0000};
    vecs[4]  = '{5'b00001, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'hFF, 4'b0000};
    vecs[5]  = '{5'b00010, 1'b0, 1'b0, 64'h5A5A, 64'h5A5A, 64'd0, 4'b0001};
    vecs[6]  = '{5'b00011, 1'b0, 1'b0, 64'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010};
    vecs[7]  = '{5'b10100, 1'b0, 1'b1, 64'd14, 64'd99, 64'd7, 4'b0000};
    vecs[8]  = '{5'b10101, 1'b0, 1'b0, 64'h8000_0000_0000_0001, 64'd0, 64'd2, 4'b0000};
    vecs[9]  = '{5'b11111, 1'b1, 1'b0, 64'd5, 64'd6, 64'd0, 4'b0001};
    vecs[10] = '{5'b10000, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0101};
    vecs[11] = '{5'b10010, 1'b1, 1'b0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010};
    vecs[12] = '{5'b10010, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100};
    vecs[13] = '{5'b10000, 1'b1, 1'b0, 64'd1, 64'd1, 64'd3, 4'b0000};
    vecs[14] = '{5'b10010, 1'b0, 1'b0, 64'd5, 64'd3, 64'd1, 4'b0100};
    vecs[15] = '{5'b10101, 1'b0, 1'b0, 64'h4000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000, 4'b0010};

    for (int i = 0; i < RC; i++) m_reg[i] = '0;

    // reset held with start and loadReg active
    bus.start = 1'b1; bus.loadReg = 1'b1; bus.op = 5'b10000; bus.cin = 1'b1; bus.muxSel = 1'b1;
    bus.readA = 5'd1; bus.readB = 5'd2; bus.writeReg = 5'd3; bus.data = 64'h1234;
    bus.wbEn = 1'b1; bus.writeRam = 1'b1; bus.ramAddr = 7'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_aluOut", bus.aluOut, 64'd0);
    check("reset_status", 64'(bus.status), 64'd0);
    check("reset_Cout", 64'(bus.Cout), 64'd0);
    check("reset_ramOut", bus.ramOut, 64'd0);
    bus.start = 1'b0; bus.loadReg = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < RC; i++) begin
      read_reg(i, v);
      check("reset_reg_zero", v, 64'd0);
    end

    // directed vector table, operands in r2/r3, result to r4 and RAM[i]
    for (int i = 0; i < 16; i++) begin
      load_reg(2, vecs[i].a);
      load_reg(3, vecs[i].b);
      do_op(vecs[i].op, vecs[i].cin, vecs[i].mux, 2, 3, 4, vecs[i].a, 1'b1, 1'b1, i, bit'(i % 2), v, s);
      check("vec_result", v, vecs[i].res);
      check("vec_status", 64'(s), 64'(vecs[i].st));
      check_ram(i);
    end

    // add with writeback to r1
    load_reg(29, 64'd14);
    load_reg(30, 64'd14);
    do_op(5'b10000, 1'b0, 1'b0, 30, 29, 1, '0, 1'b1, 1'b0, 0, 1'b1, v, s);
    check("add_result", v, 64'd28);
    check("add_status", 64'(s), 64'd0);
    read_reg(1, v);
    check("add_r1", v, 64'd28);

    // subtract and store to RAM[5], then shift right
    do_op(5'b10010, 1'b1, 1'b0, 30, 29, 0, '0, 1'b0, 1'b1, 5, 1'b1, v, s);
    check("sub_result", v, 64'd0);
    check("sub_status", 64'(s), 64'b0101);
    check_ram(5);
    check("ram5_value", bus.ramOut, 64'd0);
    do_op(5'b10100, 1'b0, 1'b0, 30, 29, 0, '0, 1'b0, 1'b0, 0, 1'b1, v, s);
    check("shr_result", v, 64'd7);

    // r31 is hardwired to zero
    load_reg(31, 64'hDEAD_BEEF);
    read_reg(31, v);
    check("r31_zero", v, 64'd0);

    // loadReg together with start: only the operation happens
    ld_extra = 1'b1;
    do_op(5'b00000, 1'b0, 1'b0, 0, 0, 8, 64'hABCD, 1'b0, 1'b0, 0, 1'b1, v, s);
    ld_extra = 1'b0;
    read_reg(8, v);
    check("load_with_start_ignored", v, m_reg[8]);

    // reset asserted during EXEC aborts writeback and RAM store
    load_reg(5, 64'd123);
    load_reg(6, 64'd1);
    @(negedge clock);
    bus.start = 1'b1; bus.op = 5'b10000; bus.cin = 1'b0; bus.muxSel = 1'b0;
    bus.readA = 5'd5; bus.readB = 5'd6; bus.writeReg = 5'd7; bus.wbEn = 1'b1;
    bus.writeRam = 1'b1; bus.ramAddr = 7'd9;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_aluOut", bus.aluOut, 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < RC; i++) m_reg[i] = '0;
    repeat (4) @(posedge clock);
    read_reg(7, v);
    check("abort_no_writeback", v, 64'd0);
    read_reg(5, v);
    check("abort_regs_cleared", v, 64'd0);
    check_ram(9);

    // random operations against the model
    for (int r = 0; r < RC - 1; r++) load_reg(r, {$urandom, $urandom});
    for (int n = 0; n < 40; n++) begin
      op   = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops_tab[$urandom_range(0, 8)];
      addr = $urandom_range(0, RD - 1);
      wram = 1'($urandom);
      do_op(op, 1'($urandom), 1'($urandom), $urandom_range(0, RC - 1), $urandom_range(0, RC - 1),
            $urandom_range(0, RC - 1), {$urandom, $urandom}, 1'($urandom), wram, addr,
            bit'($urandom_range(0, 1)), v, s);
      if (wram) check_ram(addr);
    end
    for (int r = 0; r < RC; r += 5) begin
      read_reg(r, v);
      check("random_reg_readback", v, m_reg[r]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
